// File: rtl/vga_timing.sv
// VGA raster timing generator: free-running pixel/line counters with registered
// sync, blanking, frame-start pulse and completed-frame counter.
module vga_timing #(
  parameter int H_VISIBLE = 800,
  parameter int H_FPORCH  = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BPORCH  = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FPORCH  = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BPORCH  = 23
) (
  input  logic        pclk,
  input  logic        reset,
  output logic [11:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [11:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FPORCH + H_SYNC + H_BPORCH;
  localparam int V_TOTAL = V_VISIBLE + V_FPORCH + V_SYNC + V_BPORCH;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // 13-bit bounds so a sync window ending exactly at 4096 still compares correctly.
  localparam logic [12:0] HB_BEG = 13'(H_VISIBLE);
  localparam logic [12:0] HS_BEG = 13'(H_VISIBLE + H_FPORCH);
  localparam logic [12:0] HS_END = 13'(H_VISIBLE + H_FPORCH + H_SYNC);
  localparam logic [12:0] VB_BEG = 13'(V_VISIBLE);
  localparam logic [12:0] VS_BEG = 13'(V_VISIBLE + V_FPORCH);
  localparam logic [12:0] VS_END = 13'(V_VISIBLE + V_FPORCH + V_SYNC);

  logic [11:0] r_hcount;
  logic [11:0] r_vcount;
  logic        r_hsync;
  logic        r_hblnk;
  logic        r_vsync;
  logic        r_vblnk;
  logic        r_frame_start;
  logic [15:0] r_frame_cnt;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_frame_wrap;
  logic [11:0] w_h_next;
  logic [11:0] w_v_next;
  logic [12:0] w_h_ext;
  logic [12:0] w_v_ext;

  always_comb begin
    w_h_last     = (r_hcount == H_LAST);
    w_v_last     = (r_vcount == V_LAST);
    w_frame_wrap = w_h_last && w_v_last;
    w_h_next     = w_h_last ? 12'd0 : r_hcount + 12'd1;
    w_v_next     = r_vcount;
    if (w_h_last) begin
      w_v_next = w_v_last ? 12'd0 : r_vcount + 12'd1;
    end
    w_h_ext = {1'b0, w_h_next};
    w_v_ext = {1'b0, w_v_next};
  end

  // Flags are derived from the next counter values so they line up with the
  // counters they describe once both are registered.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_hcount      <= 12'd0;
      r_vcount      <= 12'd0;
      r_hsync       <= 1'b0;
      r_hblnk       <= 1'b0;
      r_vsync       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 16'd0;
    end else begin
      r_hcount      <= w_h_next;
      r_vcount      <= w_v_next;
      r_hblnk       <= (w_h_ext >= HB_BEG);
      r_hsync       <= (w_h_ext >= HS_BEG) && (w_h_ext < HS_END);
      r_vblnk       <= (w_v_ext >= VB_BEG);
      r_vsync       <= (w_v_ext >= VS_BEG) && (w_v_ext < VS_END);
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign hblnk       = r_hblnk;
  assign vsync       = r_vsync;
  assign vblnk       = r_vblnk;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (800x600, 640x480, tiny raster) checked every
// cycle against an elapsed-cycle model, plus literal checks of key raster positions.
module tb_vga_timing;

  localparam int AH = 1056, AV = 628, AF = AH * AV;
  localparam int BH = 800,  BV = 525, BF = BH * BV;
  localparam int CH = 17,   CV = 11,  CF = CH * CV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

  logic [11:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
  logic        hs_a, hb_a, vs_a, vb_a, fs_a;
  logic        hs_b, hb_b, vs_b, vb_b, fs_b;
  logic        hs_c, hb_c, vs_c, vb_c, fs_c;
  logic [15:0] fc_a, fc_b, fc_c;

  vga_timing dut_a (
    .pclk(clk), .reset(rst_a), .hcount(hc_a), .hsync(hs_a), .hblnk(hb_a),
    .vcount(vc_a), .vsync(vs_a), .vblnk(vb_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing #(
    .H_VISIBLE(640), .H_FPORCH(16), .H_SYNC(96), .H_BPORCH(48),
    .V_VISIBLE(480), .V_FPORCH(10), .V_SYNC(2),  .V_BPORCH(33)
  ) dut_b (
    .pclk(clk), .reset(rst_b), .hcount(hc_b), .hsync(hs_b), .hblnk(hb_b),
    .vcount(vc_b), .vsync(vs_b), .vblnk(vb_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  vga_timing #(
    .H_VISIBLE(10), .H_FPORCH(2), .H_SYNC(3), .H_BPORCH(2),
    .V_VISIBLE(6),  .V_FPORCH(1), .V_SYNC(2), .V_BPORCH(2)
  ) dut_c (
    .pclk(clk), .reset(rst_c), .hcount(hc_c), .hsync(hs_c), .hblnk(hb_c),
    .vcount(vc_c), .vsync(vs_c), .vblnk(vb_c), .frame_start(fs_c), .frame_cnt(fc_c)
  );

  // Model state: cycles elapsed since reset release, plus a frame-count offset.
  int t_a = 0, t_b = 0, t_c = 0, off_c = 0;
  bit jreq_a = 1'b0, jreq_b = 1'b0, freq_c = 1'b0;
  int jv_a = 0, jv_b = 0;

  function automatic int jump_t(input int t, input int h_tot, input int f_tot, input int v);
    return (t / f_tot) * f_tot + v * h_tot + (t % h_tot) + 1;
  endfunction

  always @(posedge clk) begin
    if (rst_a) t_a <= 0;
    else t_a <= jreq_a ? jump_t(t_a, AH, AF, jv_a) : t_a + 1;
    if (rst_b) t_b <= 0;
    else t_b <= jreq_b ? jump_t(t_b, BH, BF, jv_b) : t_b + 1;
    if (rst_c) begin
      t_c   <= 0;
      off_c <= 0;
    end else begin
      t_c <= t_c + 1;
      if (freq_c) off_c <= 65535 - t_c / CF;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input int t, input int off,
                     input int ht, input int vt, input int hv, input int hf, input int hsw,
                     input int vv, input int vf, input int vsw,
                     input logic [11:0] hc, input logic [11:0] vc, input logic hs,
                     input logic hb, input logic vs, input logic vb, input logic fs,
                     input logic [15:0] fc);
    int h, v, f;
    h = t % ht;
    v = (t / ht) % vt;
    f = ht * vt;
    check({tag, "_hcount"}, int'(hc), h);
    check({tag, "_vcount"}, int'(vc), v);
    check({tag, "_hblnk"}, int'(hb), int'(h >= hv));
    check({tag, "_hsync"}, int'(hs), int'(h >= hv + hf && h < hv + hf + hsw));
    check({tag, "_vblnk"}, int'(vb), int'(v >= vv));
    check({tag, "_vsync"}, int'(vs), int'(v >= vv + vf && v < vv + vf + vsw));
    check({tag, "_frame_start"}, int'(fs), int'(t > 0 && t % f == 0));
    check({tag, "_frame_cnt"}, int'(fc), (off + t / f) & 65535);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("a", t_a, 0, AH, AV, 800, 40, 128, 600, 1, 4,
          hc_a, vc_a, hs_a, hb_a, vs_a, vb_a, fs_a, fc_a);
      cmp("b", t_b, 0, BH, BV, 640, 16, 96, 480, 10, 2,
          hc_b, vc_b, hs_b, hb_b, vs_b, vb_b, fs_b, fc_b);
      cmp("c", t_c, off_c, CH, CV, 10, 2, 3, 6, 1, 2,
          hc_c, vc_c, hs_c, hb_c, vs_c, vb_c, fs_c, fc_c);
    end
  end

  task automatic thread_a();
    int first_hb, hs_n, hs_first, hs_last, vs_n, vs_first, vs_last, vb_n;
    bit seen_fs, seen_corner, seen_vb, found;
    first_hb = -1; hs_n = 0; hs_first = -1; hs_last = -1;
    vs_n = 0; vs_first = -1; vs_last = -1; vb_n = 0;
    seen_fs = 0; seen_corner = 0; seen_vb = 0; found = 0;
    for (int i = 1; i <= AH; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("a_first_hcount", int'(hc_a), 1);
        check("a_first_vcount", int'(vc_a), 0);
        check("a_no_fs_after_reset", int'(fs_a), 0);
      end
      if (hb_a && first_hb < 0) first_hb = int'(hc_a);
      if (hs_a) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(hc_a);
        hs_last = int'(hc_a);
      end
    end
    check("a_first_hblnk_col", first_hb, 800);
    check("a_hsync_cycles", hs_n, 128);
    check("a_hsync_first", hs_first, 840);
    check("a_hsync_last", hs_last, 967);
    check("a_wrap_hcount", int'(hc_a), 0);
    check("a_wrap_vcount", int'(vc_a), 1);

    #1 force dut_a.r_vcount = 12'd599;
    jv_a = 599; jreq_a = 1'b1;
    #1 release dut_a.r_vcount;
    @(posedge clk);
    #1 jreq_a = 1'b0;
    for (int i = 0; i < 40000 && !seen_fs; i++) begin
      @(negedge clk);
      if (vs_a) begin
        vs_n++;
        if (vs_first < 0) vs_first = int'(vc_a);
        vs_last = int'(vc_a);
      end
      if (vb_a) vb_n++;
      if (hc_a == 12'd799 && vc_a == 12'd599) begin
        seen_corner = 1;
        check("a_hblnk_at_799_599", int'(hb_a), 0);
        check("a_vblnk_at_799_599", int'(vb_a), 0);
      end
      if (hc_a == 12'd0 && vc_a == 12'd600) begin
        seen_vb = 1;
        check("a_vblnk_at_0_600", int'(vb_a), 1);
      end
      if (fs_a) begin
        seen_fs = 1;
        check("a_fs_hcount", int'(hc_a), 0);
        check("a_fs_vcount", int'(vc_a), 0);
        check("a_fs_frame_cnt", int'(fc_a), 1);
      end
    end
    check("a_frame_start_seen", int'(seen_fs), 1);
    check("a_corner_seen", int'(seen_corner), 1);
    check("a_vblnk_start_seen", int'(seen_vb), 1);
    check("a_vsync_cycles", vs_n, 4224);
    check("a_vsync_first_line", vs_first, 601);
    check("a_vsync_last_line", vs_last, 604);
    check("a_vblnk_cycles", vb_n, 28 * 1056);

    #1 force dut_a.r_vcount = 12'd300;
    jv_a = 300; jreq_a = 1'b1;
    #1 release dut_a.r_vcount;
    @(posedge clk);
    #1 jreq_a = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(negedge clk);
      if (hc_a == 12'd500 && vc_a == 12'd300) found = 1;
    end
    check("a_reached_500_300", int'(found), 1);
    rst_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("a_rst_outputs_zero",
            int'(|{hc_a, vc_a, hs_a, hb_a, vs_a, vb_a, fs_a, fc_a}), 0);
    end
    rst_a = 1'b0;
    @(negedge clk);
    check("a_release_hcount", int'(hc_a), 1);
    check("a_release_vcount", int'(vc_a), 0);
    check("a_release_frame_cnt", int'(fc_a), 0);
    check("a_release_no_fs", int'(fs_a), 0);
  endtask

  task automatic thread_b();
    int first_hb, hs_n, hs_first, hs_last, vs_n, vs_first, vs_last, prev_v;
    bit seen_fs;
    first_hb = -1; hs_n = 0; hs_first = -1; hs_last = -1;
    vs_n = 0; vs_first = -1; vs_last = -1; prev_v = -1; seen_fs = 0;
    for (int i = 1; i <= BH; i++) begin
      @(negedge clk);
      if (hb_b && first_hb < 0) first_hb = int'(hc_b);
      if (hs_b) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(hc_b);
        hs_last = int'(hc_b);
      end
    end
    check("b_first_hblnk_col", first_hb, 640);
    check("b_hsync_cycles", hs_n, 96);
    check("b_hsync_first", hs_first, 656);
    check("b_hsync_last", hs_last, 751);
    check("b_line_period_hcount", int'(hc_b), 0);
    check("b_line_period_vcount", int'(vc_b), 1);

    #1 force dut_b.r_vcount = 12'd489;
    jv_b = 489; jreq_b = 1'b1;
    #1 release dut_b.r_vcount;
    @(posedge clk);
    #1 jreq_b = 1'b0;
    for (int i = 0; i < 4 * BH; i++) begin
      @(negedge clk);
      if (vs_b) begin
        vs_n++;
        if (vs_first < 0) vs_first = int'(vc_b);
        vs_last = int'(vc_b);
      end
    end
    check("b_vsync_cycles", vs_n, 1600);
    check("b_vsync_first_line", vs_first, 490);
    check("b_vsync_last_line", vs_last, 491);

    #1 force dut_b.r_vcount = 12'd524;
    jv_b = 524; jreq_b = 1'b1;
    #1 release dut_b.r_vcount;
    @(posedge clk);
    #1 jreq_b = 1'b0;
    for (int i = 0; i < 1000 && !seen_fs; i++) begin
      @(negedge clk);
      if (fs_b) begin
        seen_fs = 1;
        check("b_last_line_before_wrap", prev_v, 524);
        check("b_fs_hcount", int'(hc_b), 0);
        check("b_fs_vcount", int'(vc_b), 0);
        check("b_fs_frame_cnt", int'(fc_b), 1);
      end
      prev_v = int'(vc_b);
    end
    check("b_frame_start_seen", int'(seen_fs), 1);
  endtask

  task automatic thread_c();
    int pulse_n;
    int pulse_at[3];
    int pulse_cnt[3];
    bit seen_fs;
    pulse_n = 0; seen_fs = 0;
    for (int k = 0; k < 3; k++) begin
      pulse_at[k] = -1;
      pulse_cnt[k] = -1;
    end
    for (int i = 1; i <= 3 * CF + 5; i++) begin
      @(negedge clk);
      if (fs_c) begin
        if (pulse_n < 3) begin
          pulse_at[pulse_n]  = i;
          pulse_cnt[pulse_n] = int'(fc_c);
        end
        pulse_n++;
      end
    end
    check("c_pulse_count", pulse_n, 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("c_pulse%0d_cycle", k), pulse_at[k], (k + 1) * 187);
      check($sformatf("c_pulse%0d_frame_cnt", k), pulse_cnt[k], k + 1);
    end

    #1 force dut_c.r_frame_cnt = 16'hFFFF;
    freq_c = 1'b1;
    #1 release dut_c.r_frame_cnt;
    @(posedge clk);
    #1 freq_c = 1'b0;
    @(negedge clk);
    check("c_preloaded_frame_cnt", int'(fc_c), 65535);
    for (int i = 0; i < 250 && !seen_fs; i++) begin
      @(negedge clk);
      if (fs_c) begin
        seen_fs = 1;
        check("c_frame_cnt_wrapped", int'(fc_c), 0);
      end
    end
    check("c_wrap_pulse_seen", int'(seen_fs), 1);
  endtask

  initial begin
    @(posedge clk);
    #1 chk_on = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    fork
      thread_a();
      thread_b();
      thread_c();
    join
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have the following parameters:
  - H_VISIBLE, 800, active pixels per line
  - H_FPORCH, 40, horizontal front porch in pixels
  - H_SYNC, 128, hsync pulse width in pixels
  - H_BPORCH, 88, horizontal back porch in pixels
  - V_VISIBLE, 600, active lines per frame
  - V_FPORCH, 1, vertical front porch in lines
  - V_SYNC, 4, vsync pulse width in lines
  - V_BPORCH, 23, vertical back porch in lines
REQ-002 The block SHALL have the following ports:
  - pclk, in, 1, pixel clock (40 MHz nominal); single clock domain, all logic on its rising edge
  - reset, in, 1, synchronous, active-high
  - hcount, out, 12, current pixel column
  - hsync, out, 1, horizontal sync, active-high
  - hblnk, out, 1, horizontal blanking, high outside the visible columns
  - vcount, out, 12, current line
  - vsync, out, 1, vertical sync, active-high
  - vblnk, out, 1, vertical blanking, high outside the visible lines
  - frame_start, out, 1, one-cycle pulse at pixel (0,0) of each new frame
  - frame_cnt, out, 16, count of completed frames
REQ-003 All outputs SHALL be driven directly from flip-flops, with no combinational path from inputs to outputs.

Function
REQ-004 Derived totals: H_TOTAL = H_VISIBLE+H_FPORCH+H_SYNC+H_BPORCH (1056 by default); V_TOTAL = V_VISIBLE+V_FPORCH+V_SYNC+V_BPORCH (628 by default).
REQ-005 hcount SHALL increment by 1 on every pclk edge while reset is low, and SHALL wrap from H_TOTAL-1 to 0.
REQ-006 vcount SHALL increment by 1 only on the edge where hcount wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-007 hblnk, hsync, vblnk and vsync SHALL be cycle-aligned with the hcount/vcount values presented in the same cycle (zero skew); they are computed from the next counter values before registering.
REQ-008 hblnk SHALL be 1 exactly when hcount >= H_VISIBLE (default 800..1055).
REQ-009 hsync SHALL be 1 exactly when H_VISIBLE+H_FPORCH <= hcount < H_VISIBLE+H_FPORCH+H_SYNC (default 840..967).
REQ-010 vblnk SHALL be 1 exactly when vcount >= V_VISIBLE (default 600..627), for every hcount on those lines.
REQ-011 vsync SHALL be 1 exactly when V_VISIBLE+V_FPORCH <= vcount < V_VISIBLE+V_FPORCH+V_SYNC (default 601..604), for every hcount on those lines.
REQ-012 frame_start SHALL be 1 for exactly one cycle, namely the cycle in which the outputs show hcount=0 and vcount=0 after a wrap from (H_TOTAL-1, V_TOTAL-1); it SHALL NOT pulse on the cycle following reset.
REQ-013 frame_cnt SHALL increment by 1 on the same edge that raises frame_start, and SHALL wrap from 16'hFFFF to 0.
REQ-014 Counter widths: 12 bits; H_TOTAL and V_TOTAL SHALL be no greater than 4096, and the sync and blank comparisons SHALL be unsigned.
REQ-015 Output timing is deterministic: the frame period SHALL be exactly H_TOTAL*V_TOTAL cycles (663168 by default), and the line period SHALL be exactly H_TOTAL cycles.

Reset
REQ-016 While reset=1 at a pclk edge, the block SHALL set hcount=0, vcount=0, hsync=0, hblnk=0, vsync=0, vblnk=0, frame_start=0 and frame_cnt=0.
REQ-017 On the first edge with reset=0, the block SHALL advance to hcount=1, vcount=0.
REQ-018 Reset asserted mid-line or mid-frame SHALL abandon the current frame with no frame_start pulse and no frame_cnt increment; the restart SHALL then follow REQ-017.
REQ-019 Reset held for N cycles SHALL produce no output change other than holding the reset values.

Verification
REQ-020 Release reset, run 1056 cycles -> hcount goes 0..1055 then 0, and vcount steps 0->1 on the wrap edge; hblnk first rises at hcount=800; hsync is high for hcount 840..967 (128 cycles).
REQ-021 Run one full frame from reset -> vblnk is high from vcount=600 to 627; vsync is high for 4 lines (601..604), i.e. 4224 cycles; vblnk and hblnk are both low at (799,599) and vblnk is high at (0,600).
REQ-022 Run 3 frames -> frame_start pulses exactly 3 times, each pulse 663168 cycles apart and each a single cycle at (0,0); frame_cnt reads 1, 2, 3; there is no pulse on the first post-reset cycle.
REQ-023 Assert reset at (500,300) for 5 cycles -> all outputs are 0 during reset, frame_cnt=0, and hcount=1, vcount=0 on the first edge after release.
REQ-024 Preload frame_cnt via a force at 16'hFFFF and complete a frame -> frame_cnt=0 and frame_start still pulses.
REQ-025 Instantiate with parameters 640/16/96/48 and 480/10/2/33 -> H_TOTAL=800, V_TOTAL=525, hsync spans hcount 656..751 and vsync spans vcount 490..491.
